// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: 3-digit multiplexed common-anode 7-segment driver for BCD digits,
// with a guard cycle per slot, frame-coherent shadow capture and leading-zero blanking.
module bcd_seg_scan #(
   parameter int SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       blank_lz,
   input  logic [1:0] hundred,
   input  logic [3:0] decade,
   input  logic [3:0] unit,
   output logic [6:0] seg,
   output logic [2:0] dig_sel,
   output logic       frame_done
);
   localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {UNIT, DECADE, HUNDRED} idx_t;

   idx_t          idx, idx_nx;
   logic [PW-1:0] p, p_nx;
   logic [1:0]    sh_h;
   logic [3:0]    sh_d, sh_u, digit;
   logic          tick, wrap, blank;
   logic [6:0]    seg_nx;
   logic [2:0]    dig_nx;

   function automatic logic [6:0] dec(input logic [3:0] v);
      case (v)
         4'd0:    dec = 7'h40;
         4'd1:    dec = 7'h79;
         4'd2:    dec = 7'h24;
         4'd3:    dec = 7'h30;
         4'd4:    dec = 7'h19;
         4'd5:    dec = 7'h12;
         4'd6:    dec = 7'h02;
         4'd7:    dec = 7'h78;
         4'd8:    dec = 7'h00;
         4'd9:    dec = 7'h10;
         default: dec = 7'h06;
      endcase
   endfunction

   assign tick = p == PW'(SCAN_DIV - 1);
   assign wrap = tick && idx == HUNDRED;

   always_comb begin
      idx_nx = !en ? UNIT : !tick ? idx : idx == UNIT ? DECADE : idx == DECADE ? HUNDRED : UNIT;
      p_nx   = (!en || tick) ? '0 : p + 1'b1;
      digit  = idx == HUNDRED ? {2'b00, sh_h} : idx == DECADE ? sh_d : sh_u;
      // hundred blanks on zero; decade only when hundred is also zero
      blank  = blank_lz && sh_h == 2'd0 && (idx == HUNDRED || (idx == DECADE && sh_d == 4'd0));
      seg_nx = (!en || p == '0 || blank) ? 7'h7F : dec(digit);
      dig_nx = (!en || p == '0) ? 3'b111 : idx == UNIT ? 3'b110 : idx == DECADE ? 3'b101 : 3'b011;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p          <= '0;
         idx        <= UNIT;
         sh_h       <= '0;
         sh_d       <= '0;
         sh_u       <= '0;
         seg        <= 7'h7F;
         dig_sel    <= 3'b111;
         frame_done <= 1'b0;
      end else begin
         p          <= p_nx;
         idx        <= idx_nx;
         seg        <= seg_nx;
         dig_sel    <= dig_nx;
         frame_done <= en && wrap;
         if (!en || wrap) begin
            sh_h <= hundred;
            sh_d <= decade;
            sh_u <= unit;
         end
      end
   end
endmodule

// File: tb/tb_bcd_seg_scan.sv
// tb_bcd_seg_scan: directed checks of scan timing, decode, blanking, frame capture,
// enable drop and asynchronous reset with SCAN_DIV=4 (12-cycle frame).
module tb_bcd_seg_scan;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        en = 1'b0;
   logic        blank_lz = 1'b0;
   logic [1:0]  hundred = '0;
   logic [3:0]  decade = '0;
   logic [3:0]  unit = '0;
   logic [6:0]  seg;
   logic [2:0]  dig_sel;
   logic        frame_done;
   logic [10:0] obs;
   int          tests = 0;
   int          fails = 0;

   bcd_seg_scan #(.SCAN_DIV(4)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .blank_lz(blank_lz),
      .hundred(hundred), .decade(decade), .unit(unit),
      .seg(seg), .dig_sel(dig_sel), .frame_done(frame_done)
   );

   always #5 clk = ~clk;
   assign obs = {dig_sel, seg, frame_done};

   // Expected {dig_sel, seg, frame_done} k edges after enable rises (k from 1).
   function automatic logic [10:0] expv(input int k, input logic [6:0] su, input logic [6:0] sd,
                                        input logic [6:0] sh);
      int ph, sl;
      logic [2:0] d;
      logic [6:0] s;
      ph = (k - 1) % 4;
      sl = ((k - 1) / 4) % 3;
      d  = ph == 0 ? 3'b111 : sl == 0 ? 3'b110 : sl == 1 ? 3'b101 : 3'b011;
      s  = ph == 0 ? 7'h7F : sl == 0 ? su : sl == 1 ? sd : sh;
      return {d, s, k % 12 == 0};
   endfunction

   task automatic restart(input logic [1:0] h, input logic [3:0] d, input logic [3:0] u,
                          input logic bl);
      hundred = h; decade = d; unit = u; blank_lz = bl; en = 1'b0;
      @(posedge clk); #1;
      en = 1'b1;
   endtask

   task automatic test_reset;
      #2 rst_n = 1'b0;
      #1 tests++;
      if (obs !== {3'b111, 7'h7F, 1'b0}) begin
         fails++;
         $display("FAIL reset_async: got %h want %h", obs, {3'b111, 7'h7F, 1'b0});
      end
      repeat (2) @(posedge clk);
      #1 tests++;
      if (obs !== {3'b111, 7'h7F, 1'b0}) begin
         fails++;
         $display("FAIL reset_held: got %h want %h", obs, {3'b111, 7'h7F, 1'b0});
      end
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_scan;
      restart(2'd2, 4'd5, 4'd5, 1'b0);
      for (int k = 1; k <= 24; k++) begin
         @(posedge clk); #1;
         tests++;
         if (obs !== expv(k, 7'h12, 7'h12, 7'h24)) begin
            fails++;
            $display("FAIL scan k=%0d: got %h want %h", k, obs, expv(k, 7'h12, 7'h12, 7'h24));
         end
      end
   endtask

   task automatic test_decode;
      // {hundred, decade, unit, blank_lz, seg_unit, seg_decade, seg_hundred}
      logic [31:0] tv [6];
      logic [31:0] r;
      tv = '{ {2'd0, 4'd0,   4'd7,   1'b1, 7'h78, 7'h7F, 7'h7F},
              {2'd0, 4'd0,   4'd0,   1'b1, 7'h40, 7'h7F, 7'h7F},
              {2'd1, 4'd0,   4'd3,   1'b1, 7'h30, 7'h40, 7'h79},
              {2'd0, 4'd0,   4'hC,   1'b0, 7'h06, 7'h40, 7'h40},
              {2'd0, 4'hF,   4'd9,   1'b1, 7'h10, 7'h06, 7'h7F},
              {2'd2, 4'd8,   4'd1,   1'b1, 7'h79, 7'h00, 7'h24} };
      for (int i = 0; i < 6; i++) begin
         r = tv[i];
         restart(r[31:30], r[29:26], r[25:22], r[21]);
         for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            tests++;
            if (obs !== expv(k, r[20:14], r[13:7], r[6:0])) begin
               fails++;
               $display("FAIL decode row=%0d k=%0d: got %h want %h", i, k, obs,
                        expv(k, r[20:14], r[13:7], r[6:0]));
            end
         end
      end
   endtask

   task automatic test_midframe;
      logic [10:0] e;
      restart(2'd1, 4'd2, 4'd3, 1'b0);
      for (int k = 1; k <= 24; k++) begin
         @(posedge clk); #1;
         e = k <= 12 ? expv(k, 7'h30, 7'h24, 7'h79) : expv(k, 7'h02, 7'h19, 7'h24);
         tests++;
         if (obs !== e) begin
            fails++;
            $display("FAIL midframe k=%0d: got %h want %h", k, obs, e);
         end
         if (k == 6) begin
            hundred = 2'd2; decade = 4'd4; unit = 4'd6;
         end
      end
   endtask

   task automatic test_en_drop;
      logic [10:0] e [4];
      e = '{ {3'b111, 7'h7F, 1'b0}, {3'b111, 7'h7F, 1'b0},
             {3'b111, 7'h7F, 1'b0}, {3'b110, 7'h30, 1'b0} };
      restart(2'd1, 4'd2, 4'd3, 1'b0);
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         tests++;
         if (obs !== expv(k, 7'h30, 7'h24, 7'h79)) begin
            fails++;
            $display("FAIL en_drop_pre k=%0d: got %h want %h", k, obs, expv(k, 7'h30, 7'h24, 7'h79));
         end
      end
      en = 1'b0;
      for (int j = 0; j < 4; j++) begin
         if (j == 2) en = 1'b1;
         @(posedge clk); #1;
         tests++;
         if (obs !== e[j]) begin
            fails++;
            $display("FAIL en_drop step=%0d: got %h want %h", j, obs, e[j]);
         end
      end
   endtask

   task automatic test_async_reset;
      logic [10:0] e;
      restart(2'd1, 4'd2, 4'd3, 1'b0);
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         tests++;
         if (obs !== expv(k, 7'h30, 7'h24, 7'h79)) begin
            fails++;
            $display("FAIL areset_pre k=%0d: got %h want %h", k, obs, expv(k, 7'h30, 7'h24, 7'h79));
         end
      end
      #2 rst_n = 1'b0;
      #1 tests++;
      if (obs !== {3'b111, 7'h7F, 1'b0}) begin
         fails++;
         $display("FAIL areset_mid: got %h want %h", obs, {3'b111, 7'h7F, 1'b0});
      end
      @(negedge clk) rst_n = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(posedge clk); #1;
         e = k <= 12 ? expv(k, 7'h40, 7'h40, 7'h40) : expv(k, 7'h30, 7'h24, 7'h79);
         tests++;
         if (obs !== e) begin
            fails++;
            $display("FAIL areset_post k=%0d: got %h want %h", k, obs, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_decode();
      test_midframe();
      test_en_drop();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/bcd_seg_scan.md
Name: bcd_seg_scan

Overview:
Downstream consumer of the 8-bit binary-to-BCD converter. Takes hundred/decade/unit digits and drives a 3-digit multiplexed common-anode 7-segment display. Uses a time-sliced scan with an anti-ghosting guard cycle, frame-coherent input capture, and optional leading-zero blanking. Sits between the converter outputs and the board display pins.

Parameters:
SCAN_DIV, 50000, clock cycles per digit slot; legal range >= 2.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
en  input  1  scan enable; low = display dark, scan held.
blank_lz  input  1  1 = blank leading zeros.
hundred  input  2  BCD hundreds digit (0..2 from converter).
decade  input  4  BCD tens digit.
unit  input  4  BCD units digit.
seg  output  7  {g,f,e,d,c,b,a}, active low.
dig_sel  output  3  digit enables, active low; [0]=unit, [1]=decade, [2]=hundred.
frame_done  output  1  one-cycle pulse at each frame wrap.

Behaviour:
- Reset, asynchronous and active-low: prescaler=0, idx=UNIT, shadow={0,0,0}, seg=7'h7F, dig_sel=3'b111, frame_done=0.
- Prescaler p counts 0..SCAN_DIV-1 and wraps; tick = (p==SCAN_DIV-1).
- idx FSM: UNIT -> DECADE -> HUNDRED -> UNIT, advancing on tick only.
- Shadow registers (hundred, decade, unit) load from inputs every cycle while en=0, and on the tick edge where idx goes HUNDRED->UNIT. Mid-frame input changes are never displayed until the next frame.
- frame_done is registered and high for exactly the one cycle following the HUNDRED->UNIT edge.
- Output registers, one-cycle latency from (p, idx):
  - p==0 is the guard cycle: dig_sel=3'b111 and seg=7'h7F.
  - p in 1..SCAN_DIV-1: dig_sel has a single active-low bit for idx; seg = decode(shadow digit).
- Decode (hex, active low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - Values 10..15 display 'E' = 06.
  - A blanked digit gives seg=7F, but dig_sel is still driven as normal.
- Leading-zero blanking (blank_lz=1):
  - Hundred is blanked if shadow hundred==0.
  - Decade is blanked if shadow hundred==0 and shadow decade==0.
  - Unit is never blanked.
- The hundred digit is zero-extended to 4 bits before decode.
- en=0 (synchronous): p forced to 0, idx forced to UNIT, frame_done=0, and outputs go dark on the next edge.
  - On en rising, the scan restarts with a UNIT slot, beginning with its guard cycle.
- Reset asserted mid-slot: all state clears immediately. The first frame after reset release shows shadow={0,0,0} until the first wrap, unless en=0 loads the shadow first.

Test Plan:
- SCAN_DIV=4, en=1, blank_lz=0, inputs 2/5/5, held en=0 one cycle then en=1 -> repeating 12-cycle frame.
  - Per slot: dig_sel 111 for 1 cycle, then 110 / 101 / 011 for 3 cycles each.
  - seg: 12 on unit, 12 on decade, 24 on hundred.
  - frame_done pulses once per 12 cycles.
- blank_lz=1, inputs 0/0/7 -> unit seg=78; decade and hundred seg=7F, with dig_sel still cycling. Inputs 0/0/0 -> unit seg=40.
- blank_lz=1, inputs 1/0/3 -> decade shows 40, not blanked (hundred!=0); hundred shows 79.
- Change inputs from 1/2/3 to 2/4/6 during the DECADE slot -> the remainder of the frame shows 1/2/3; 2/4/6 appears from the next UNIT slot, coincident with the frame_done pulse.
- Drive unit=4'hC -> unit seg=06. Drop en mid-HUNDRED slot -> next cycle dig_sel=111, seg=7F; on re-enable, the scan restarts at UNIT with a guard cycle.
- Assert rst_n=0 mid-DECADE slot, asynchronously between edges -> outputs go 7F/111 immediately and frame_done=0; after release, the scan starts at UNIT.
